// File: rtl/tl_pkg.sv
// Shared TileLink-UL definitions for the 64-bit data, 31-bit address,
// 9-bit source crossbar port.
//   - width localparams for the A/D payload fields
//   - packed payload structs tl_a_t / tl_d_t
//   - A and D channel opcode constants used on this port
package tl_pkg;

  localparam int TL_SRC_W  = 9;
  localparam int TL_ADDR_W = 31;
  localparam int TL_DATA_W = 64;
  localparam int TL_SIZE_W = 2;
  localparam int TL_MASK_W = TL_DATA_W / 8;

  // A channel opcodes (TL-UL subset)
  localparam logic [2:0] TL_A_PUT_FULL_DATA    = 3'd0;
  localparam logic [2:0] TL_A_PUT_PARTIAL_DATA = 3'd1;
  localparam logic [2:0] TL_A_GET              = 3'd4;

  // D channel opcodes (TL-UL subset)
  localparam logic [2:0] TL_D_ACCESS_ACK      = 3'd0;
  localparam logic [2:0] TL_D_ACCESS_ACK_DATA = 3'd1;

  typedef struct packed {
    logic [2:0]           opcode;
    logic [2:0]           param;
    logic [TL_SIZE_W-1:0] size;
    logic [TL_SRC_W-1:0]  source;
    logic [TL_ADDR_W-1:0] address;
    logic [TL_MASK_W-1:0] mask;
    logic [TL_DATA_W-1:0] data;
    logic                 corrupt;
  } tl_a_t;

  typedef struct packed {
    logic [2:0]           opcode;
    logic [1:0]           param;
    logic [TL_SIZE_W-1:0] size;
    logic [TL_SRC_W-1:0]  source;
    logic                 sink;
    logic                 denied;
    logic [TL_DATA_W-1:0] data;
    logic                 corrupt;
  } tl_d_t;

endpackage

// File: rtl/tl_fifo.sv
// Generic registered FIFO with no flow-through: a pushed entry becomes
// visible on pop_data one cycle later. push_ready depends only on the
// registered occupancy, so there is no combinational path from pop.
// Ports:
//   clock       in   clock
//   reset       in   asynchronous reset, active low
//   push_valid  in   write request
//   push_ready  out  not full
//   push_data   in   WIDTH-bit entry
//   pop         in   consume the head entry (ignored when empty)
//   pop_valid   out  FIFO not empty
//   pop_data    out  head entry, stable until popped
module tl_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             push_valid,
  output logic             push_ready,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic             pop_valid,
  output logic [WIDTH-1:0] pop_data
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int OCC_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [OCC_W-1:0] occ;
  logic             do_push;
  logic             do_pop;

  // Pointers wrap explicitly so that non-power-of-two depths work.
  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign push_ready = (occ != OCC_W'(DEPTH));
  assign pop_valid  = (occ != '0);
  assign do_push    = push_valid && push_ready;
  assign do_pop     = pop && pop_valid;
  assign pop_data   = mem[rd_ptr];

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      occ    <= '0;
    end else begin
      if (do_push) wr_ptr <= next_ptr(wr_ptr);
      if (do_pop)  rd_ptr <= next_ptr(rd_ptr);
      case ({do_push, do_pop})
        2'b10:   occ <= occ + 1'b1;
        2'b01:   occ <= occ - 1'b1;
        default: occ <= occ;
      endcase
    end
  end

  // Storage needs no reset; only the pointers/occupancy define validity.
  always_ff @(posedge clock) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/tl_inflight_limiter.sv
// TileLink-UL A/D stage that queues the A channel and caps the number of
// outstanding requests (A issued, D not yet returned) at MAX_INFLIGHT.
// Every A produces exactly one D beat, so each D fire retires one request.
// The D channel is a pure combinational pass-through.
// Optional feature macro: TL_INFLIGHT_WDOG_EN adds a sticky wdog_timeout
// output set when requests stay outstanding with no D for WDOG_CYCLES-1 cycles.
// Ports:
//   clock, reset (async, active low)
//   auto_in_a_*   upstream A (ready out, valid/bits in)
//   auto_in_d_*   upstream D (ready in, valid/bits out)
//   auto_out_a_*  downstream A (ready in, valid/bits out)
//   auto_out_d_*  downstream D (ready out, valid/bits in)
//   inflight_count  current outstanding request count
//   err_underflow   sticky: a D beat fired while nothing was outstanding
//   wdog_timeout    sticky watchdog flag (TL_INFLIGHT_WDOG_EN only)
module tl_inflight_limiter
  import tl_pkg::*;
#(
  parameter int MAX_INFLIGHT = 8,
  parameter int QUEUE_DEPTH  = 2,
  parameter int WDOG_CYCLES  = 1024
) (
  input  logic                               clock,
  input  logic                               reset,
  output logic                               auto_in_a_ready,
  input  logic                               auto_in_a_valid,
  input  logic [2:0]                         auto_in_a_bits_opcode,
  input  logic [2:0]                         auto_in_a_bits_param,
  input  logic [1:0]                         auto_in_a_bits_size,
  input  logic [8:0]                         auto_in_a_bits_source,
  input  logic [30:0]                        auto_in_a_bits_address,
  input  logic [7:0]                         auto_in_a_bits_mask,
  input  logic [63:0]                        auto_in_a_bits_data,
  input  logic                               auto_in_a_bits_corrupt,
  input  logic                               auto_in_d_ready,
  output logic                               auto_in_d_valid,
  output logic [2:0]                         auto_in_d_bits_opcode,
  output logic [1:0]                         auto_in_d_bits_param,
  output logic [1:0]                         auto_in_d_bits_size,
  output logic [8:0]                         auto_in_d_bits_source,
  output logic                               auto_in_d_bits_sink,
  output logic                               auto_in_d_bits_denied,
  output logic [63:0]                        auto_in_d_bits_data,
  output logic                               auto_in_d_bits_corrupt,
  input  logic                               auto_out_a_ready,
  output logic                               auto_out_a_valid,
  output logic [2:0]                         auto_out_a_bits_opcode,
  output logic [2:0]                         auto_out_a_bits_param,
  output logic [1:0]                         auto_out_a_bits_size,
  output logic [8:0]                         auto_out_a_bits_source,
  output logic [30:0]                        auto_out_a_bits_address,
  output logic [7:0]                         auto_out_a_bits_mask,
  output logic [63:0]                        auto_out_a_bits_data,
  output logic                               auto_out_a_bits_corrupt,
  output logic                               auto_out_d_ready,
  input  logic                               auto_out_d_valid,
  input  logic [2:0]                         auto_out_d_bits_opcode,
  input  logic [1:0]                         auto_out_d_bits_param,
  input  logic [1:0]                         auto_out_d_bits_size,
  input  logic [8:0]                         auto_out_d_bits_source,
  input  logic                               auto_out_d_bits_sink,
  input  logic                               auto_out_d_bits_denied,
  input  logic [63:0]                        auto_out_d_bits_data,
  input  logic                               auto_out_d_bits_corrupt,
`ifdef TL_INFLIGHT_WDOG_EN
  output logic                               wdog_timeout,
`endif
  output logic [$clog2(MAX_INFLIGHT+1)-1:0]  inflight_count,
  output logic                               err_underflow
);

  localparam int CNT_W = $clog2(MAX_INFLIGHT + 1);
  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_INFLIGHT);

  tl_a_t a_in;
  tl_a_t a_out;
  logic  q_nonempty;
  logic  allow;
  logic  a_fire;
  logic  d_fire;

  assign a_in = '{opcode:  auto_in_a_bits_opcode,  param: auto_in_a_bits_param,
                  size:    auto_in_a_bits_size,    source: auto_in_a_bits_source,
                  address: auto_in_a_bits_address, mask: auto_in_a_bits_mask,
                  data:    auto_in_a_bits_data,    corrupt: auto_in_a_bits_corrupt};

  tl_fifo #(
    .WIDTH($bits(tl_a_t)),
    .DEPTH(QUEUE_DEPTH)
  ) u_a_queue (
    .clock      (clock),
    .reset      (reset),
    .push_valid (auto_in_a_valid),
    .push_ready (auto_in_a_ready),
    .push_data  (a_in),
    .pop        (a_fire),
    .pop_valid  (q_nonempty),
    .pop_data   (a_out)
  );

  // A D beat in the same cycle is deliberately not credited here; this keeps
  // allow a function of registered state so it cannot drop while valid is up.
  assign allow            = (inflight_count < MAX_CNT);
  assign auto_out_a_valid = q_nonempty && allow;
  assign a_fire           = auto_out_a_valid && auto_out_a_ready;

  assign auto_out_a_bits_opcode  = a_out.opcode;
  assign auto_out_a_bits_param   = a_out.param;
  assign auto_out_a_bits_size    = a_out.size;
  assign auto_out_a_bits_source  = a_out.source;
  assign auto_out_a_bits_address = a_out.address;
  assign auto_out_a_bits_mask    = a_out.mask;
  assign auto_out_a_bits_data    = a_out.data;
  assign auto_out_a_bits_corrupt = a_out.corrupt;

  assign auto_in_d_valid        = auto_out_d_valid;
  assign auto_in_d_bits_opcode  = auto_out_d_bits_opcode;
  assign auto_in_d_bits_param   = auto_out_d_bits_param;
  assign auto_in_d_bits_size    = auto_out_d_bits_size;
  assign auto_in_d_bits_source  = auto_out_d_bits_source;
  assign auto_in_d_bits_sink    = auto_out_d_bits_sink;
  assign auto_in_d_bits_denied  = auto_out_d_bits_denied;
  assign auto_in_d_bits_data    = auto_out_d_bits_data;
  assign auto_in_d_bits_corrupt = auto_out_d_bits_corrupt;
  assign auto_out_d_ready       = auto_in_d_ready;
  assign d_fire                 = auto_out_d_valid && auto_in_d_ready;

  // A retirement with nothing outstanding is a protocol error: the count
  // holds at zero and the sticky flag records it.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      inflight_count <= '0;
      err_underflow  <= 1'b0;
    end else if (a_fire && !d_fire) begin
      inflight_count <= inflight_count + 1'b1;
    end else if (d_fire && !a_fire) begin
      if (inflight_count == '0) err_underflow  <= 1'b1;
      else                      inflight_count <= inflight_count - 1'b1;
    end
  end

`ifdef TL_INFLIGHT_WDOG_EN
  localparam int WD_W = $clog2(WDOG_CYCLES);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(WDOG_CYCLES - 1);

  logic [WD_W-1:0] wdog_cnt;
  logic [WD_W-1:0] wdog_next;

  // The counter saturates at its limit; the flag fires on the cycle the
  // counter reaches the limit so the timeout is visible without extra delay.
  always_comb begin
    wdog_next = wdog_cnt;
    if (d_fire || inflight_count == '0) wdog_next = '0;
    else if (wdog_cnt != WD_LAST)       wdog_next = wdog_cnt + 1'b1;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wdog_cnt     <= '0;
      wdog_timeout <= 1'b0;
    end else begin
      wdog_cnt <= wdog_next;
      if (wdog_next == WD_LAST) wdog_timeout <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_tl_inflight_limiter.sv
// Self-checking bench for tl_inflight_limiter: directed scenarios plus a
// randomized run, all checked against a queue/integer reference model.
module tb_tl_inflight_limiter;
  import tl_pkg::*;

  localparam int MAX   = 8;
  localparam int QD    = 2;
  localparam int CNT_W = $clog2(MAX + 1);

  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;

  logic in_a_valid, out_a_ready, in_d_ready, out_d_valid;
  tl_a_t drv_a;
  tl_d_t drv_d;

  logic in_a_ready, out_a_valid, out_d_ready, in_d_valid, err_underflow;
  logic [CNT_W-1:0] inflight_count;
  logic [2:0] oa_opcode, oa_param, id_opcode;
  logic [1:0] oa_size, id_param, id_size;
  logic [8:0] oa_source, id_source;
  logic [30:0] oa_address;
  logic [7:0] oa_mask;
  logic [63:0] oa_data, id_data;
  logic oa_corrupt, id_sink, id_denied, id_corrupt;
`ifdef TL_INFLIGHT_WDOG_EN
  logic wdog_timeout;
`endif

  tl_a_t dut_a;
  tl_d_t dut_d;
  assign dut_a = '{opcode: oa_opcode, param: oa_param, size: oa_size, source: oa_source,
                   address: oa_address, mask: oa_mask, data: oa_data, corrupt: oa_corrupt};
  assign dut_d = '{opcode: id_opcode, param: id_param, size: id_size, source: id_source,
                   sink: id_sink, denied: id_denied, data: id_data, corrupt: id_corrupt};

  tl_inflight_limiter #(.MAX_INFLIGHT(MAX), .QUEUE_DEPTH(QD), .WDOG_CYCLES(16)) dut (
    .clock(clock), .reset(reset),
    .auto_in_a_ready(in_a_ready), .auto_in_a_valid(in_a_valid),
    .auto_in_a_bits_opcode(drv_a.opcode), .auto_in_a_bits_param(drv_a.param),
    .auto_in_a_bits_size(drv_a.size), .auto_in_a_bits_source(drv_a.source),
    .auto_in_a_bits_address(drv_a.address), .auto_in_a_bits_mask(drv_a.mask),
    .auto_in_a_bits_data(drv_a.data), .auto_in_a_bits_corrupt(drv_a.corrupt),
    .auto_in_d_ready(in_d_ready), .auto_in_d_valid(in_d_valid),
    .auto_in_d_bits_opcode(id_opcode), .auto_in_d_bits_param(id_param),
    .auto_in_d_bits_size(id_size), .auto_in_d_bits_source(id_source),
    .auto_in_d_bits_sink(id_sink), .auto_in_d_bits_denied(id_denied),
    .auto_in_d_bits_data(id_data), .auto_in_d_bits_corrupt(id_corrupt),
    .auto_out_a_ready(out_a_ready), .auto_out_a_valid(out_a_valid),
    .auto_out_a_bits_opcode(oa_opcode), .auto_out_a_bits_param(oa_param),
    .auto_out_a_bits_size(oa_size), .auto_out_a_bits_source(oa_source),
    .auto_out_a_bits_address(oa_address), .auto_out_a_bits_mask(oa_mask),
    .auto_out_a_bits_data(oa_data), .auto_out_a_bits_corrupt(oa_corrupt),
    .auto_out_d_ready(out_d_ready), .auto_out_d_valid(out_d_valid),
    .auto_out_d_bits_opcode(drv_d.opcode), .auto_out_d_bits_param(drv_d.param),
    .auto_out_d_bits_size(drv_d.size), .auto_out_d_bits_source(drv_d.source),
    .auto_out_d_bits_sink(drv_d.sink), .auto_out_d_bits_denied(drv_d.denied),
    .auto_out_d_bits_data(drv_d.data), .auto_out_d_bits_corrupt(drv_d.corrupt),
`ifdef TL_INFLIGHT_WDOG_EN
    .wdog_timeout(wdog_timeout),
`endif
    .inflight_count(inflight_count), .err_underflow(err_underflow)
  );

  // Reference model: queued requests, outstanding count, sticky error.
  tl_a_t mq[$];
  int    mcnt;
  bit    merr;
  int    a_fires;
  int    checks;
  int    passes;

  function automatic tl_a_t rand_a();
    tl_a_t a;
    a = '{opcode: TL_A_GET, param: 3'($urandom), size: 2'($urandom), source: 9'($urandom),
          address: 31'($urandom), mask: 8'($urandom), data: {$urandom, $urandom},
          corrupt: 1'($urandom)};
    return a;
  endfunction

  function automatic tl_d_t rand_d();
    tl_d_t d;
    d = '{opcode: TL_D_ACCESS_ACK_DATA, param: 2'($urandom), size: 2'($urandom),
          source: 9'($urandom), sink: 1'($urandom), denied: 1'($urandom),
          data: {$urandom, $urandom}, corrupt: 1'($urandom)};
    return d;
  endfunction

  // Advance one clock; the model applies the fires implied by the inputs.
  task automatic tick();
    bit m_push, m_pop, m_dfire;
    #1;
    m_push  = in_a_valid && (mq.size() < QD);
    m_pop   = (mq.size() > 0) && (mcnt < MAX) && out_a_ready;
    m_dfire = out_d_valid && in_d_ready;
    if (out_a_valid === 1'b1 && out_a_ready) a_fires++;
    @(posedge clock);
    if (m_pop) void'(mq.pop_front());
    if (m_push) mq.push_back(drv_a);
    if (m_pop && !m_dfire) mcnt++;
    else if (m_dfire && !m_pop) begin
      if (mcnt == 0) merr = 1'b1;
      else mcnt--;
    end
    #1;
  endtask

  task automatic idle_inputs();
    in_a_valid = 0; out_a_ready = 0; in_d_ready = 0; out_d_valid = 0;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset = 1'b0;
    mq.delete(); mcnt = 0; merr = 0;
    repeat (2) @(posedge clock);
    @(negedge clock) reset = 1'b1;
    #1;
  endtask

  // Retire everything outstanding so the next scenario starts from idle.
  task automatic drain();
    in_a_valid = 0; out_a_ready = 1; in_d_ready = 1;
    for (int i = 0; i < 60 && (mq.size() > 0 || mcnt > 0); i++) begin
      out_d_valid = (mcnt > 0);
      drv_d = rand_d();
      tick();
    end
    idle_inputs();
  endtask

  task automatic test_reset();
    idle_inputs();
    drv_a = rand_a(); drv_d = rand_d();
    reset = 1'b0;
    #3;
    checks++; if (in_a_ready !== 1'b1) $display("[TB] FAIL reset_in_a_ready: got %b want 1", in_a_ready); else passes++;
    checks++; if (out_a_valid !== 1'b0) $display("[TB] FAIL reset_out_a_valid: got %b want 0", out_a_valid); else passes++;
    checks++; if (inflight_count !== '0) $display("[TB] FAIL reset_count: got %0d want 0", inflight_count); else passes++;
    checks++; if (err_underflow !== 1'b0) $display("[TB] FAIL reset_err: got %b want 0", err_underflow); else passes++;
    out_d_valid = 1; in_d_ready = 1;
    #1;
    checks++; if (dut_d !== drv_d || in_d_valid !== 1'b1 || out_d_ready !== 1'b1)
      $display("[TB] FAIL reset_d_passthru: got %h want %h", dut_d, drv_d); else passes++;
    idle_inputs();
    @(negedge clock) reset = 1'b1;
    #1;
  endtask

  task automatic test_single_get();
    tl_a_t req;
    req = rand_a();
    req.opcode = TL_A_GET; req.source = 9'h005; req.address = 31'h1000_0000;
    drv_a = req; in_a_valid = 1; out_a_ready = 1;
    #1;
    checks++; if (out_a_valid !== 1'b0) $display("[TB] FAIL get_no_flowthrough: got %b want 0", out_a_valid); else passes++;
    tick();
    in_a_valid = 0;
    #1;
    checks++; if (out_a_valid !== 1'b1 || dut_a !== req) $display("[TB] FAIL get_out_a: got %b/%h want 1/%h", out_a_valid, dut_a, req); else passes++;
    tick();
    checks++; if (inflight_count !== CNT_W'(1) || mcnt != 1) $display("[TB] FAIL get_count_1: got %0d want 1", inflight_count); else passes++;
    drv_d = rand_d(); drv_d.source = 9'h005; out_d_valid = 1; in_d_ready = 1;
    #1;
    checks++; if (dut_d !== drv_d) $display("[TB] FAIL get_d_payload: got %h want %h", dut_d, drv_d); else passes++;
    tick();
    out_d_valid = 0;
    checks++; if (inflight_count !== '0) $display("[TB] FAIL get_count_0: got %0d want 0", inflight_count); else passes++;
    idle_inputs();
  endtask

  task automatic test_back_to_back();
    a_fires = 0;
    in_a_valid = 1; out_a_ready = 1;
    for (int i = 0; i < 14; i++) begin
      drv_a = rand_a();
      tick();
    end
    in_a_valid = 0;
    #1;
    checks++; if (a_fires != MAX) $display("[TB] FAIL b2b_fires: got %0d want %0d", a_fires, MAX); else passes++;
    checks++; if (out_a_valid !== 1'b0 || in_a_ready !== 1'b0) $display("[TB] FAIL b2b_blocked: got v=%b r=%b want 0/0", out_a_valid, in_a_ready); else passes++;
    checks++; if (inflight_count !== CNT_W'(MAX)) $display("[TB] FAIL b2b_count: got %0d want %0d", inflight_count, MAX); else passes++;
    out_d_valid = 1; in_d_ready = 1; drv_d = rand_d();
    tick();
    out_d_valid = 0;
    #1;
    checks++; if (out_a_valid !== 1'b1 || dut_a !== mq[0]) $display("[TB] FAIL b2b_reissue_valid: got %b want 1", out_a_valid); else passes++;
    tick();
    checks++; if (a_fires != MAX + 1 || inflight_count !== CNT_W'(MAX)) $display("[TB] FAIL b2b_ninth: got fires=%0d cnt=%0d want %0d/%0d", a_fires, inflight_count, MAX + 1, MAX); else passes++;
    drain();
  endtask

  task automatic test_simultaneous();
    in_a_valid = 1; out_a_ready = 1;
    repeat (3) begin drv_a = rand_a(); tick(); end
    in_a_valid = 0;
    tick();
    checks++; if (inflight_count !== CNT_W'(3)) $display("[TB] FAIL simul_pre_count: got %0d want 3", inflight_count); else passes++;
    in_a_valid = 1; drv_a = rand_a();
    tick();
    in_a_valid = 0; out_d_valid = 1; in_d_ready = 1; drv_d = rand_d();
    #1;
    checks++; if (out_a_valid !== 1'b1) $display("[TB] FAIL simul_valid: got %b want 1", out_a_valid); else passes++;
    tick();
    out_d_valid = 0;
    checks++; if (inflight_count !== CNT_W'(3) || mcnt != 3) $display("[TB] FAIL simul_count: got %0d want 3", inflight_count); else passes++;
    drain();
  endtask

  task automatic test_backpressure();
    tl_a_t first;
    int accepted;
    accepted = 0;
    out_a_ready = 0; in_a_valid = 1;
    for (int i = 0; i < 5; i++) begin
      drv_a = rand_a();
      drv_a.data = 64'hDEAD_BEEF_CAFE_F00D;
      drv_a.address = 31'h100 + 31'(i);
      if (i == 0) first = drv_a;
      #1;
      if (in_a_ready === 1'b1) accepted++;
      if (i > 0) begin
        checks++; if (out_a_valid !== 1'b1 || dut_a !== first) $display("[TB] FAIL bp_hold_%0d: got %h want %h", i, dut_a, first); else passes++;
      end
      tick();
    end
    in_a_valid = 0;
    checks++; if (accepted != QD) $display("[TB] FAIL bp_accepted: got %0d want %0d", accepted, QD); else passes++;
    drain();
  endtask

  task automatic test_underflow_reset();
    out_d_valid = 1; in_d_ready = 1; drv_d = rand_d();
    tick();
    out_d_valid = 0;
    checks++; if (err_underflow !== 1'b1 || inflight_count !== '0) $display("[TB] FAIL uf_set: got err=%b cnt=%0d want 1/0", err_underflow, inflight_count); else passes++;
    in_a_valid = 1; out_a_ready = 1;
    repeat (4) begin drv_a = rand_a(); tick(); end
    checks++; if (err_underflow !== 1'b1 || inflight_count === '0) $display("[TB] FAIL uf_sticky: got err=%b cnt=%0d want 1/nonzero", err_underflow, inflight_count); else passes++;
    #2 reset = 1'b0;
    mq.delete(); mcnt = 0; merr = 0;
    #1;
    checks++; if (err_underflow !== 1'b0 || inflight_count !== '0 || out_a_valid !== 1'b0 || in_a_ready !== 1'b1)
      $display("[TB] FAIL uf_async_reset: got err=%b cnt=%0d v=%b r=%b want 0/0/0/1", err_underflow, inflight_count, out_a_valid, in_a_ready); else passes++;
    idle_inputs();
    @(negedge clock) reset = 1'b1;
    #1;
    out_d_valid = 1; in_d_ready = 1;
    tick();
    out_d_valid = 0;
    checks++; if (err_underflow !== 1'b1) $display("[TB] FAIL uf_stale_d: got %b want 1", err_underflow); else passes++;
    do_reset();
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      in_a_valid  = ($urandom_range(0, 9) < 6);
      out_a_ready = ($urandom_range(0, 9) < 7);
      in_d_ready  = ($urandom_range(0, 9) < 8);
      out_d_valid = (mcnt > 0) ? ($urandom_range(0, 9) < 4) : ($urandom_range(0, 63) == 0);
      drv_a = rand_a(); drv_d = rand_d();
      #1;
      checks++; if (in_a_ready !== (mq.size() < QD)) $display("[TB] FAIL rnd_in_ready @%0d: got %b want %b", i, in_a_ready, mq.size() < QD); else passes++;
      checks++; if (out_a_valid !== (mq.size() > 0 && mcnt < MAX)) $display("[TB] FAIL rnd_out_valid @%0d: got %b", i, out_a_valid); else passes++;
      if (mq.size() > 0) begin
        checks++; if (dut_a !== mq[0]) $display("[TB] FAIL rnd_payload @%0d: got %h want %h", i, dut_a, mq[0]); else passes++;
      end
      checks++; if (inflight_count !== CNT_W'(mcnt)) $display("[TB] FAIL rnd_count @%0d: got %0d want %0d", i, inflight_count, mcnt); else passes++;
      checks++; if (err_underflow !== merr) $display("[TB] FAIL rnd_err @%0d: got %b want %b", i, err_underflow, merr); else passes++;
      tick();
    end
    drain();
  endtask

`ifdef TL_INFLIGHT_WDOG_EN
  task automatic test_wdog();
    do_reset();
    in_a_valid = 1; out_a_ready = 1; drv_a = rand_a();
    tick();
    in_a_valid = 0;
    tick();
    for (int c = 1; c <= 15; c++) begin
      tick();
      if (c == 14) begin
        checks++; if (wdog_timeout !== 1'b0) $display("[TB] FAIL wdog_early: got %b want 0", wdog_timeout); else passes++;
      end
    end
    checks++; if (wdog_timeout !== 1'b1) $display("[TB] FAIL wdog_fire: got %b want 1", wdog_timeout); else passes++;
    do_reset();
    in_a_valid = 1; out_a_ready = 1; drv_a = rand_a();
    tick();
    in_a_valid = 0;
    tick();
    repeat (9) tick();
    out_d_valid = 1; in_d_ready = 1;
    tick();
    out_d_valid = 0;
    repeat (20) tick();
    checks++; if (wdog_timeout !== 1'b0) $display("[TB] FAIL wdog_cleared: got %b want 0", wdog_timeout); else passes++;
    do_reset();
  endtask
`endif

  initial begin
    checks = 0; passes = 0; a_fires = 0;
    mcnt = 0; merr = 0;
    test_reset();
    test_single_get();
    test_back_to_back();
    test_simultaneous();
    test_backpressure();
    test_underflow_reset();
    test_random();
`ifdef TL_INFLIGHT_WDOG_EN
    test_wdog();
`endif
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/tl_inflight_limiter.md
Name: tl_inflight_limiter

Overview:
- TileLink-UL A/D stage placed directly upstream of the pass-through TL buffer node on the 64-bit, 31-bit-address, 9-bit-source crossbar port.
- Decouples the A channel through a small registered queue.
- Caps the number of outstanding requests (A issued, D not yet returned) at MAX_INFLIGHT.
- D channel passes through combinationally; each D beat retires one request. All sizes are ≤ 8 bytes, so every A produces exactly one D beat.

Parameters:
- MAX_INFLIGHT, 8: maximum outstanding requests; legal range 1..255.
- QUEUE_DEPTH, 2: A-channel queue entries; legal range 2..8.
- WDOG_CYCLES, 1024: watchdog limit in cycles; used only with the optional feature.

Ports:
- clock  in  1  single clock.
- reset  in  1  asynchronous, active-low; asserted when 0.
- auto_in_a_ready  out  1  upstream A ready.
- auto_in_a_valid  in  1  upstream A valid.
- auto_in_a_bits_{opcode,param,size,source,address,mask,data,corrupt}  in  3/3/2/9/31/8/64/1  upstream A payload.
- auto_in_d_ready  in  1  upstream D ready.
- auto_in_d_valid, auto_in_d_bits_{opcode,param,size,source,sink,denied,data,corrupt}  out  1, 3/2/2/9/1/1/64/1  upstream D.
- auto_out_a_ready  in  1  downstream A ready.
- auto_out_a_valid, auto_out_a_bits_*  out  widths as auto_in_a  downstream A.
- auto_out_d_ready  out  1  downstream D ready.
- auto_out_d_valid, auto_out_d_bits_*  in  widths as auto_in_d  downstream D.
- inflight_count  out  $clog2(MAX_INFLIGHT+1)  current outstanding count.
- err_underflow  out  1  sticky: a D beat fired with count 0.

Behaviour:
- Reset values:
  - Queue empty; auto_out_a_valid=0; auto_in_a_ready=1.
  - inflight_count=0; err_underflow=0.
  - D outputs follow their inputs; they are combinational.
- A queue:
  - FIFO of QUEUE_DEPTH full payloads.
  - auto_in_a_ready = !full. It is a registered function of occupancy only, with no combinational path from auto_out_a_ready.
  - Push when in_a_valid && in_a_ready.
  - Pushed entry is visible at the output the next cycle. No flow-through, so minimum latency is 1 cycle.
  - With depth ≥ 2, sustained throughput is 1 beat/cycle.
  - Push and pop in the same cycle leave occupancy unchanged.
  - When full, in_a_ready=0 even if a pop happens that cycle.
  - Payload is held stable while out_a_valid && !out_a_ready, per the TL rule.
- Issue gating:
  - allow = (inflight_count < MAX_INFLIGHT). Same-cycle D retirement is not credited.
  - auto_out_a_valid = q_nonempty && allow.
  - Pop when auto_out_a_valid && auto_out_a_ready.
  - Once out_a_valid is asserted, allow cannot drop before the fire, because only an A fire increments the count.
- D path:
  - auto_in_d_* = auto_out_d_*; auto_out_d_ready = auto_in_d_ready.
  - d_fire = auto_out_d_valid && auto_in_d_ready.
- Counter update:
  - A fire only: +1.
  - d_fire only: -1.
  - Both: unchanged.
  - d_fire with count 0 and no A fire: count stays 0 and err_underflow sets.
  - err_underflow clears only on reset.
  - Count never exceeds MAX_INFLIGHT.
- Asynchronous reset mid-operation drops all queued and outstanding state immediately. Any later D beats for old requests trigger err_underflow.

Optional Feature:
- Macro: TL_INFLIGHT_WDOG_EN.
- When defined:
  - Adds output wdog_timeout (1 bit, sticky, reset 0).
  - A cycle counter runs while inflight_count>0 and no d_fire occurs.
  - The counter clears on d_fire or when the count is 0.
  - wdog_timeout sets when the counter reaches WDOG_CYCLES-1.
  - Gating and data paths are unaffected.
- When undefined: no port and no counter logic.

Decomposition:
- Shared package tl_pkg:
  - Width localparams: TL_SRC_W=9, TL_ADDR_W=31, TL_DATA_W=64, TL_SIZE_W=2.
  - Packed typedefs tl_a_t and tl_d_t.
  - Opcode constants.
- One sub-module, tl_fifo: a generic parameterised-depth registered FIFO, instantiated for the A queue.

Test Plan:
- Reset, single Get (opcode 4, source 0x05, address 0x1000_0000):
  - out_a_valid rises 1 cycle after in fire.
  - count goes 0→1.
  - D returned on the next cycle → count 0; in_d payload equals out_d.
- Back-to-back requests with out_a_ready=1 and no D: exactly 8 A fires, then out_a_valid=0 with the queue full and in_a_ready=0. One D beat → the 9th A fires the following cycle.
- A fire and D fire in the same cycle at count=3 → count stays 3.
- Backpressure: out_a_ready=0 for 5 cycles with data 0xDEADBEEF_CAFEF00D → payload held stable, and at most QUEUE_DEPTH entries accepted.
- D beat at count 0 → err_underflow=1, count stays 0; it stays set until reset is asserted low mid-burst, then all state returns to reset values.
- With TL_INFLIGHT_WDOG_EN and WDOG_CYCLES=16: 1 request and no D → wdog_timeout asserts on cycle 15 after issue. A D at cycle 10 prevents the timeout.
